noc_adder_inj_ctrl: RTL

//  Hardware packet-injection sequencer sitting directly upstream of noc_adder_top.

---
 rtl/noc_adder_inj_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/noc_adder_inj_ctrl.sv
// Packet-injection sequencer for noc_adder_top: issues START/START2 pairs for a
// programmed number of packets, captures each DONE result, and aborts on a hang.
module noc_adder_inj_ctrl #(
    parameter int unsigned DATAW       = 32,
    parameter int unsigned CNTW        = 16,
    parameter int unsigned GAPW        = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             GO,
    input  logic [CNTW-1:0]  CFG_NUM_PKT,
    input  logic [GAPW-1:0]  CFG_GAP,
    output logic             START,
    output logic             START2,
    input  logic             DONE,
    input  logic [DATAW-1:0] DATA_I,
    output logic             RES_VALID,
    output logic [DATAW-1:0] RES_DATA,
    output logic [CNTW-1:0]  RES_IDX,
    output logic [CNTW-1:0]  PKT_CNT,
    output logic             BUSY,
    output logic             CAMPAIGN_DONE,
    output logic             TIMEOUT_ERR
);

    localparam int unsigned TOW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        INJ1,
        INJ2,
        WAIT_DONE,
        GAP,
        FIN
    } state_t;

    state_t          state, next_state;
    logic            done_q;
    logic            done_rise;
    logic [CNTW-1:0] num_q;
    logic [GAPW-1:0] gap_q;
    logic [GAPW-1:0] gap_cnt;
    logic [TOW-1:0]  to_cnt;
    logic [CNTW-1:0] pkt_cnt_inc;

    assign pkt_cnt_inc = PKT_CNT + CNTW'(1);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode; completion is a rising DONE edge seen in WAIT_DONE only
    always_comb begin
        next_state = state;
        done_rise  = DONE & ~done_q;
        case (state)
            IDLE: begin
                if (GO) next_state = (CFG_NUM_PKT != '0) ? INJ1 : FIN;
            end
            INJ1: next_state = INJ2;
            INJ2: next_state = WAIT_DONE;
            WAIT_DONE: begin
                if (done_rise) begin
                    // PKT_CNT increments this same edge, so compare against its successor
                    if (gap_q != '0)               next_state = GAP;
                    else if (pkt_cnt_inc == num_q) next_state = FIN;
                    else                           next_state = INJ1;
                end else if (to_cnt == TO_LAST) begin
                    next_state = FIN;
                end
            end
            GAP: begin
                if (gap_cnt == '0) next_state = (PKT_CNT == num_q) ? FIN : INJ1;
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs, config latches, and packet/gap/timeout counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            done_q        <= 1'b0;
            START         <= 1'b0;
            START2        <= 1'b0;
            BUSY          <= 1'b0;
            CAMPAIGN_DONE <= 1'b0;
            RES_VALID     <= 1'b0;
            RES_DATA      <= '0;
            RES_IDX       <= '0;
            PKT_CNT       <= '0;
            TIMEOUT_ERR   <= 1'b0;
            num_q         <= '0;
            gap_q         <= '0;
            gap_cnt       <= '0;
            to_cnt        <= '0;
        end else begin
            done_q        <= DONE;
            START         <= (next_state == INJ1);
            START2        <= (next_state == INJ2);
            BUSY          <= (next_state != IDLE);
            CAMPAIGN_DONE <= (state == FIN);
            RES_VALID     <= 1'b0;
            case (state)
                IDLE: begin
                    if (GO) begin
                        num_q       <= CFG_NUM_PKT;
                        gap_q       <= CFG_GAP;
                        PKT_CNT     <= '0;
                        TIMEOUT_ERR <= 1'b0;
                    end
                end
                INJ2: to_cnt <= '0;
                WAIT_DONE: begin
                    if (done_rise) begin
                        RES_DATA  <= DATA_I;
                        RES_IDX   <= PKT_CNT;
                        RES_VALID <= 1'b1;
                        PKT_CNT   <= pkt_cnt_inc;
                        // Loaded with gap-1 so GAP lasts exactly gap cycles
                        gap_cnt   <= gap_q - GAPW'(1);
                    end else if (to_cnt == TO_LAST) begin
                        TIMEOUT_ERR <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TOW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - GAPW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
